// File: rtl/blackjack_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : blackjack_pkg
//  Purpose  : Shared types and constants for the blackjack hand scorer:
//             FSM state encoding, result codes, deck constants, default
//             stand/bust limits and hand-scoring helper functions.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package blackjack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ADD    = 3'd3,
    ST_PLAYER = 3'd4,
    ST_DEALER = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  localparam logic [1:0] RES_PUSH   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_DEALER = 2'b10;

  localparam int DECK_SIZE            = 52;
  localparam int RANKS                = 13;
  localparam int DEFAULT_DEALER_STAND = 17;
  localparam int DEFAULT_BUST_LIMIT   = 21;

  // An ace can be promoted from 1 to 11 only while that keeps the hand
  // within the bust limit; at most one ace is ever promoted.
  function automatic logic hand_soft(input logic [4:0] hard, input logic ace,
                                     input int limit);
    return ace && ((int'(hard) + 10) <= limit);
  endfunction

  function automatic logic [4:0] hand_best(input logic [4:0] hard, input logic ace,
                                           input int limit);
    return hand_soft(hard, ace, limit) ? hard + 5'd10 : hard;
  endfunction

endpackage : blackjack_pkg
`default_nettype wire

// File: rtl/card_value.sv
`default_nettype none
// ============================================================================
//  Module   : card_value
//  Purpose  : Combinational card index to point value mapping.
//             rank = index mod 13; rank 0 is an ace (value 1, is_ace=1),
//             ranks 1..8 score rank+1, ranks 9..12 score 10.
//  Ports    : index  [5:0] in  - card index from the sequencer
//             value  [3:0] out - point value of the card
//             is_ace       out - card is an ace
//  Revision : 1.0  initial release
// ============================================================================
module card_value
  import blackjack_pkg::*;
(
  input  logic [5:0] index,
  output logic [3:0] value,
  output logic       is_ace
);

  logic [5:0] rank;

  always_comb begin
    rank   = index % 6'(RANKS);
    value  = 4'd0;
    is_ace = 1'b0;
    if (rank == 6'd0) begin
      value  = 4'd1;
      is_ace = 1'b1;
    end else if (rank <= 6'd8) begin
      value  = 4'(rank + 6'd1);
    end else begin
      value  = 4'd10;
    end
  end

endmodule : card_value
`default_nettype wire

// File: rtl/blackjack_hand_scorer.sv
`default_nettype none
// ============================================================================
//  Module   : blackjack_hand_scorer
//  Purpose  : Runs one blackjack round against a card sequencer: initial
//             deal (P, D, P, D), player hit/stand decisions, dealer play to
//             the stand limit and the final result.
//  Ports    : clock, reset (async, active-high)
//             deal_start, player_hit, player_stand   - control levels
//             card_index[5:0], card_valid            - sequencer card
//             card_request                           - draw pulse (REQ state)
//             card_dealt[5:0], card_to_dealer        - last accepted card
//             card_strobe                            - high during ADD
//             player_total/dealer_total[4:0], player_soft,
//             player_bust, dealer_bust               - hand status
//             busy, result_valid, result[1:0]        - round status
//  Revision : 1.0  initial release
// ============================================================================
module blackjack_hand_scorer
  import blackjack_pkg::*;
#(
  parameter int DEALER_STAND = DEFAULT_DEALER_STAND,
  parameter int BUST_LIMIT   = DEFAULT_BUST_LIMIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       deal_start,
  input  logic       player_hit,
  input  logic       player_stand,
  input  logic [5:0] card_index,
  input  logic       card_valid,
  output logic       card_request,
  output logic [5:0] card_dealt,
  output logic       card_to_dealer,
  output logic       card_strobe,
  output logic [4:0] player_total,
  output logic [4:0] dealer_total,
  output logic       player_soft,
  output logic       player_bust,
  output logic       dealer_bust,
  output logic       busy,
  output logic       result_valid,
  output logic [1:0] result
);

  state_t     state, next_state;

  logic [1:0] deal_cnt;
  logic       dealing;
  logic       target_dealer;
  logic [4:0] p_hard, d_hard;
  logic       p_ace, d_ace;
  logic [5:0] held_index;
  logic [3:0] held_value;
  logic       held_ace;
  logic [1:0] result_r;
  logic [5:0] dealt_r;
  logic       to_dealer_r;

  // Control from the next-state logic
  logic       start_round;
  logic       set_target;
  logic       req_target;
  logic       load_result;
  logic [1:0] result_next;

  logic [3:0] cv_value;
  logic       cv_ace;
  logic       accept;

  logic [4:0] base_hard, sum_hard, sum_best, p_best, d_best;
  logic       base_ace, sum_ace, sum_bust;

  card_value u_card_value (
    .index  (card_index),
    .value  (cv_value),
    .is_ace (cv_ace)
  );

  assign accept = (state == ST_WAIT) && card_valid && (card_index < 6'(DECK_SIZE));

  // Hand that the card in ADD is being added to, and the resulting score.
  // Hard sum cannot wrap: player hits from at most 20, dealer from at most 16.
  assign base_hard = target_dealer ? d_hard : p_hard;
  assign base_ace  = target_dealer ? d_ace  : p_ace;
  assign sum_hard  = base_hard + {1'b0, held_value};
  assign sum_ace   = base_ace | held_ace;
  assign sum_best  = hand_best(sum_hard, sum_ace, BUST_LIMIT);
  assign sum_bust  = int'(sum_hard) > BUST_LIMIT;

  assign p_best    = hand_best(p_hard, p_ace, BUST_LIMIT);
  assign d_best    = hand_best(d_hard, d_ace, BUST_LIMIT);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    next_state  = state;
    start_round = 1'b0;
    set_target  = 1'b0;
    req_target  = 1'b0;
    load_result = 1'b0;
    result_next = RES_PUSH;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (deal_start) begin
          next_state  = ST_REQ;
          start_round = 1'b1;
          set_target  = 1'b1;
          req_target  = 1'b0;
        end
      end

      ST_REQ: next_state = ST_WAIT;

      ST_WAIT: begin
        if (accept) next_state = ST_ADD;
      end

      ST_ADD: begin
        if (dealing) begin
          if (deal_cnt == 2'd3) begin
            next_state = ST_PLAYER;
          end else begin
            // Deal order alternates player, dealer, player, dealer
            next_state = ST_REQ;
            set_target = 1'b1;
            req_target = ~deal_cnt[0];
          end
        end else if (!target_dealer) begin
          if (sum_bust) begin
            next_state  = ST_DONE;
            load_result = 1'b1;
            result_next = RES_DEALER;
          end else if (int'(sum_best) == BUST_LIMIT) begin
            next_state = ST_DEALER;
          end else begin
            next_state = ST_PLAYER;
          end
        end else begin
          if (sum_bust) begin
            next_state  = ST_DONE;
            load_result = 1'b1;
            result_next = RES_PLAYER;
          end else begin
            next_state = ST_DEALER;
          end
        end
      end

      ST_PLAYER: begin
        // Stand has priority over hit; a dealt 21 stands automatically
        if (player_stand || (int'(p_best) == BUST_LIMIT)) begin
          next_state = ST_DEALER;
        end else if (player_hit) begin
          next_state = ST_REQ;
          set_target = 1'b1;
          req_target = 1'b0;
        end
      end

      ST_DEALER: begin
        if (int'(d_best) < DEALER_STAND) begin
          next_state = ST_REQ;
          set_target = 1'b1;
          req_target = 1'b1;
        end else begin
          next_state  = ST_DONE;
          load_result = 1'b1;
          if (p_best > d_best)      result_next = RES_PLAYER;
          else if (p_best < d_best) result_next = RES_DEALER;
          else                      result_next = RES_PUSH;
        end
      end

      default: next_state = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: captured card, hand accumulators, deal counter, result
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deal_cnt      <= 2'd0;
      dealing       <= 1'b0;
      target_dealer <= 1'b0;
      p_hard        <= 5'd0;
      p_ace         <= 1'b0;
      d_hard        <= 5'd0;
      d_ace         <= 1'b0;
      held_index    <= 6'd0;
      held_value    <= 4'd0;
      held_ace      <= 1'b0;
      result_r      <= RES_PUSH;
      dealt_r       <= 6'd0;
      to_dealer_r   <= 1'b0;
    end else begin
      if (start_round) begin
        p_hard   <= 5'd0;
        p_ace    <= 1'b0;
        d_hard   <= 5'd0;
        d_ace    <= 1'b0;
        result_r <= RES_PUSH;
        deal_cnt <= 2'd0;
        dealing  <= 1'b1;
      end

      if (set_target) target_dealer <= req_target;

      // Card is valued at accept and applied one cycle later in ADD
      if (accept) begin
        held_index <= card_index;
        held_value <= cv_value;
        held_ace   <= cv_ace;
      end

      if (state == ST_ADD) begin
        if (target_dealer) begin
          d_hard <= sum_hard;
          d_ace  <= sum_ace;
        end else begin
          p_hard <= sum_hard;
          p_ace  <= sum_ace;
        end
        dealt_r     <= held_index;
        to_dealer_r <= target_dealer;
        if (dealing) begin
          deal_cnt <= deal_cnt + 2'd1;
          if (deal_cnt == 2'd3) dealing <= 1'b0;
        end
      end

      if (load_result) result_r <= result_next;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign card_request   = (state == ST_REQ);
  assign card_strobe    = (state == ST_ADD);
  assign card_dealt     = dealt_r;
  assign card_to_dealer = to_dealer_r;
  assign player_total   = p_best;
  assign dealer_total   = d_best;
  assign player_soft    = hand_soft(p_hard, p_ace, BUST_LIMIT);
  assign player_bust    = int'(p_hard) > BUST_LIMIT;
  assign dealer_bust    = int'(d_hard) > BUST_LIMIT;
  assign busy           = (state != ST_IDLE) && (state != ST_DONE);
  assign result_valid   = (state == ST_DONE);
  assign result         = result_r;

endmodule : blackjack_hand_scorer
`default_nettype wire

// File: tb/tb_blackjack_hand_scorer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_blackjack_hand_scorer
//  Purpose  : Scoreboard testbench for blackjack_hand_scorer. Stimulus plays
//             the sequencer and the player; expected per-card hand state and
//             round results are queued and checked by an independent monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_blackjack_hand_scorer;
  import blackjack_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       deal_start = 1'b0;
  logic       player_hit = 1'b0;
  logic       player_stand = 1'b0;
  logic [5:0] card_index = 6'd0;
  logic       card_valid = 1'b0;

  logic       card_request;
  logic [5:0] card_dealt;
  logic       card_to_dealer;
  logic       card_strobe;
  logic [4:0] player_total;
  logic [4:0] dealer_total;
  logic       player_soft;
  logic       player_bust;
  logic       dealer_bust;
  logic       busy;
  logic       result_valid;
  logic [1:0] result;

  blackjack_hand_scorer dut (
    .clock          (clock),
    .reset          (reset),
    .deal_start     (deal_start),
    .player_hit     (player_hit),
    .player_stand   (player_stand),
    .card_index     (card_index),
    .card_valid     (card_valid),
    .card_request   (card_request),
    .card_dealt     (card_dealt),
    .card_to_dealer (card_to_dealer),
    .card_strobe    (card_strobe),
    .player_total   (player_total),
    .dealer_total   (dealer_total),
    .player_soft    (player_soft),
    .player_bust    (player_bust),
    .dealer_bust    (dealer_bust),
    .busy           (busy),
    .result_valid   (result_valid),
    .result         (result)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0] idx;
    logic       tod;
    logic [4:0] pt;
    logic [4:0] dt;
    logic       ps;
    logic       pb;
    logic       db;
  } card_exp_t;

  card_exp_t  card_q[$];
  logic [1:0] res_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor: one cycle after each card_strobe the hand state is compared with
  // the next queued card expectation; each rise of result_valid pops a result.
  // --------------------------------------------------------------------------
  logic      strobe_d = 1'b0;
  logic      rv_d = 1'b0;
  card_exp_t e;
  logic [1:0] er;

  always @(negedge clock) begin
    if (reset) begin
      strobe_d = 1'b0;
      rv_d     = 1'b0;
    end else begin
      if (strobe_d) begin
        checks++;
        if (card_q.size() == 0) begin
          errors++;
          $display("FAIL card_unexpected: got dealt=%0d with no card expected", card_dealt);
        end else begin
          e = card_q.pop_front();
          if (card_dealt !== e.idx || card_to_dealer !== e.tod || player_total !== e.pt ||
              dealer_total !== e.dt || player_soft !== e.ps || player_bust !== e.pb ||
              dealer_bust !== e.db) begin
            errors++;
            $display("FAIL card_state: got idx=%0d dlr=%0b p=%0d d=%0d soft=%0b pb=%0b db=%0b expected idx=%0d dlr=%0b p=%0d d=%0d soft=%0b pb=%0b db=%0b",
                     card_dealt, card_to_dealer, player_total, dealer_total, player_soft,
                     player_bust, dealer_bust, e.idx, e.tod, e.pt, e.dt, e.ps, e.pb, e.db);
          end
        end
      end
      if (result_valid && !rv_d) begin
        checks++;
        if (res_q.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected: got result=%b with no result expected", result);
        end else begin
          er = res_q.pop_front();
          if (result !== er) begin
            errors++;
            $display("FAIL result: got %b expected %b", result, er);
          end
        end
      end
      strobe_d = card_strobe;
      rv_d     = result_valid;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (all called at a negative clock edge)
  // --------------------------------------------------------------------------
  task automatic start_round();
    deal_start = 1'b1;
    @(negedge clock);
    deal_start = 1'b0;
    chk("request_one_cycle_after_start", card_request, 1);
    chk("start_clears_result_valid", result_valid, 0);
    chk("start_clears_totals", {player_total, dealer_total}, 0);
    chk("start_clears_flags", {player_soft, player_bust, dealer_bust, result}, 0);
  endtask

  // Act as the sequencer for one draw: wait for the request, optionally
  // present an out-of-deck index and/or hold valid low, then deliver idx.
  task automatic serve(input logic [5:0] idx, input logic tod, input int pt, input int dt,
                       input logic ps, input logic pb, input logic db,
                       input int delay, input logic bogus);
    int n = 0;
    while (!card_request && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("request_seen", card_request, 1);
    if (!card_request) return;
    player_hit   = 1'b0;
    player_stand = 1'b0;
    @(negedge clock);
    if (bogus) begin
      card_valid = 1'b1;
      card_index = 6'd55;
      @(negedge clock);
      card_valid = 1'b0;
      chk("out_of_deck_index_rejected", card_strobe, 0);
    end
    for (int i = 0; i < delay; i++) begin
      chk("wait_request_low", card_request, 0);
      chk("wait_busy", busy, 1);
      @(negedge clock);
    end
    card_q.push_back('{idx, tod, 5'(pt), 5'(dt), ps, pb, db});
    card_valid = 1'b1;
    card_index = idx;
    @(negedge clock);
    card_valid = 1'b0;
    card_index = 6'd63;
    chk("strobe_in_add", card_strobe, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!result_valid && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("round_done", result_valid, 1);
    player_hit   = 1'b0;
    player_stand = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqs;

    // Reset values
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_control_outputs", {card_request, card_strobe, busy, result_valid}, 0);
    chk("reset_card_outputs", {card_dealt, card_to_dealer}, 0);
    chk("reset_totals", {player_total, dealer_total}, 0);
    chk("reset_flags", {player_soft, player_bust, dealer_bust, result}, 0);

    // Reset while waiting for a card
    start_round();
    @(negedge clock);
    chk("in_wait_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("midwait_reset_outputs", {card_request, card_strobe, busy, result_valid, result}, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_after_reset", busy, 0);

    // Soft blackjack, player auto-stands, dealer draws an ace to 17
    res_q.push_back(RES_PLAYER);
    start_round();
    serve(6'd0,  1'b0, 11, 0,  1'b1, 1'b0, 1'b0, 0, 1'b0);
    serve(6'd9,  1'b1, 11, 10, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    serve(6'd12, 1'b0, 21, 10, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    serve(6'd5,  1'b1, 21, 16, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    serve(6'd13, 1'b1, 21, 17, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    wait_done();

    // Player busts on a hit; dealer never draws
    res_q.push_back(RES_DEALER);
    start_round();
    serve(6'd8,  1'b0, 9,  0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    serve(6'd1,  1'b1, 9,  2, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    serve(6'd7,  1'b0, 17, 2, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    serve(6'd3,  1'b1, 17, 6, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    player_hit = 1'b1;
    serve(6'd11, 1'b0, 27, 6, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    wait_done();
    reqs = 0;
    repeat (10) begin
      @(negedge clock);
      if (card_request) reqs++;
    end
    chk("no_request_after_bust", reqs, 0);
    chk("result_held_after_bust", {result_valid, result}, {1'b1, RES_DEALER});

    // Soft 16 becomes hard 16 after a ten; dealer 18 wins
    res_q.push_back(RES_DEALER);
    start_round();
    serve(6'd0,  1'b0, 11, 0,  1'b1, 1'b0, 1'b0, 0, 1'b0);
    serve(6'd9,  1'b1, 11, 10, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    serve(6'd4,  1'b0, 16, 10, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    serve(6'd7,  1'b1, 16, 18, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    player_hit = 1'b1;
    serve(6'd22, 1'b0, 16, 18, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    player_stand = 1'b1;
    wait_done();

    // Push at 20 each, with a 3-cycle invalid gap on one draw
    res_q.push_back(RES_PUSH);
    start_round();
    serve(6'd10, 1'b0, 10, 0,  1'b0, 1'b0, 1'b0, 0, 1'b0);
    serve(6'd11, 1'b1, 10, 10, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    serve(6'd12, 1'b0, 20, 10, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    serve(6'd23, 1'b1, 20, 20, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    player_stand = 1'b1;
    wait_done();

    // Hit and stand together: stand wins, next card goes to the dealer
    res_q.push_back(RES_DEALER);
    start_round();
    serve(6'd1, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    serve(6'd2, 1'b1, 2, 3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    serve(6'd3, 1'b0, 6, 3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    serve(6'd4, 1'b1, 6, 8, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    player_hit   = 1'b1;
    player_stand = 1'b1;
    serve(6'd9, 1'b1, 6, 18, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    wait_done();

    // Dealer busts from 16; one out-of-deck index is offered and skipped
    res_q.push_back(RES_PLAYER);
    start_round();
    serve(6'd10, 1'b0, 10, 0,  1'b0, 1'b0, 1'b0, 0, 1'b0);
    serve(6'd9,  1'b1, 10, 10, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    serve(6'd8,  1'b0, 19, 10, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    serve(6'd5,  1'b1, 19, 16, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    player_stand = 1'b1;
    serve(6'd12, 1'b1, 19, 26, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    wait_done();

    repeat (3) @(negedge clock);
    chk("all_cards_observed", card_q.size(), 0);
    chk("all_results_observed", res_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_blackjack_hand_scorer
`default_nettype wire
